// File: rtl/game_fsm_nxn.sv
// N x N, K-in-a-row game controller: cursor/place keys, sequential win/draw walk; outputs registered, update one cycle after an accepted key.
// Keys arriving while o_busy (CHECK/HILITE) are dropped, not queued; define WIN_HIGHLIGHT_EN for the winning-cell HILITE pass.
module game_fsm_nxn #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [2:0]         i_key_value,
    input  logic               i_key_valid,
    output logic [4*N*N-1:0]   o_control_array,
    output logic               o_turn,
    output logic [1:0]         o_game_state,
    output logic               o_busy
);
    localparam int CELLS = N * N;
    localparam int CW    = $clog2(N);
    localparam int IW    = $clog2(CELLS);
    localparam int MCW   = $clog2(CELLS + 1);
    localparam int OW    = $clog2(2 * K - 1);
    localparam int RW    = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_CHECK = 2'd1,
`ifdef WIN_HIGHLIGHT_EN
        S_OVER  = 2'd2,
        S_HILITE = 2'd3
`else
        S_OVER  = 2'd2
`endif
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [CELLS-1:0][1:0]   r_board, w_board_nxt;
    logic [CELLS-1:0]        r_hl, w_hl_nxt;
    logic [CW-1:0]           r_crow, r_ccol, w_crow_nxt, w_ccol_nxt;
    logic [CW-1:0]           r_prow, r_pcol, w_prow_nxt, w_pcol_nxt;
    logic [1:0]              r_pmark, w_pmark_nxt;
    logic [1:0]              r_dir, w_dir_nxt;
    logic [OW-1:0]           r_off, w_off_nxt;
    logic [RW-1:0]           r_run, w_run_nxt, w_run_inc;
    logic                    r_turn, w_turn_nxt;
    logic [1:0]              r_gstate, w_gstate_nxt;
    logic [MCW-1:0]          r_moves, w_moves_nxt;
    logic [4*CELLS-1:0]      r_ctrl, w_ctrl_nxt;
    logic                    r_busy, w_busy_nxt;
    logic [IW-1:0]           w_cidx, w_cidx_nxt, w_tidx;
    int                      w_o, w_tr, w_tc;
    logic                    w_inb, w_match, w_newgame;

    assign w_cidx     = IW'(int'(r_crow) * N + int'(r_ccol));
    assign w_cidx_nxt = IW'(int'(w_crow_nxt) * N + int'(w_ccol_nxt));
    assign w_newgame  = i_key_valid && (i_key_value == 3'd5) && (r_state == S_PLAY || r_state == S_OVER);

    // Cell under test: placed cell shifted by the signed walk offset along the current direction.
    always_comb begin
        w_o  = int'(r_off) - (K - 1);
        w_tr = int'(r_prow);
        w_tc = int'(r_pcol);
        case (r_dir)
            2'd0:    w_tc = w_tc + w_o;
            2'd1:    w_tr = w_tr + w_o;
            2'd2:    begin w_tr = w_tr + w_o; w_tc = w_tc + w_o; end
            default: begin w_tr = w_tr + w_o; w_tc = w_tc - w_o; end
        endcase
        w_inb     = (w_tr >= 0) && (w_tr < N) && (w_tc >= 0) && (w_tc < N);
        w_tidx    = w_inb ? IW'(w_tr * N + w_tc) : '0;
        w_match   = w_inb && (r_board[w_tidx] == r_pmark);
        w_run_inc = w_match ? r_run + RW'(1) : '0;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_board_nxt  = r_board;
        w_hl_nxt     = r_hl;
        w_crow_nxt   = r_crow;
        w_ccol_nxt   = r_ccol;
        w_prow_nxt   = r_prow;
        w_pcol_nxt   = r_pcol;
        w_pmark_nxt  = r_pmark;
        w_dir_nxt    = r_dir;
        w_off_nxt    = r_off;
        w_run_nxt    = r_run;
        w_turn_nxt   = r_turn;
        w_gstate_nxt = r_gstate;
        w_moves_nxt  = r_moves;
        case (r_state)
            S_PLAY: begin
                if (i_key_valid) begin
                    case (i_key_value)
                        3'd0: w_crow_nxt = (r_crow == '0) ? CW'(N - 1) : r_crow - CW'(1);
                        3'd1: w_crow_nxt = (r_crow == CW'(N - 1)) ? '0 : r_crow + CW'(1);
                        3'd2: w_ccol_nxt = (r_ccol == '0) ? CW'(N - 1) : r_ccol - CW'(1);
                        3'd3: w_ccol_nxt = (r_ccol == CW'(N - 1)) ? '0 : r_ccol + CW'(1);
                        3'd4: begin
                            if (r_board[w_cidx] == 2'b00) begin
                                w_board_nxt[w_cidx] = r_turn ? 2'b10 : 2'b01;
                                w_pmark_nxt = r_turn ? 2'b10 : 2'b01;
                                w_moves_nxt = r_moves + MCW'(1);
                                w_prow_nxt  = r_crow;
                                w_pcol_nxt  = r_ccol;
                                w_dir_nxt   = 2'd0;
                                w_off_nxt   = '0;
                                w_run_nxt   = '0;
                                w_state_nxt = S_CHECK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CHECK: begin
                if (w_run_inc == RW'(K)) begin
                    w_gstate_nxt = r_pmark;
                    w_run_nxt    = w_run_inc;
`ifdef WIN_HIGHLIGHT_EN
                    w_state_nxt  = S_HILITE;
`else
                    w_state_nxt  = S_OVER;
`endif
                end else if (r_off == OW'(2 * K - 2)) begin
                    w_off_nxt = '0;
                    w_run_nxt = '0;
                    w_dir_nxt = r_dir + 2'd1;
                    if (r_dir == 2'd3) begin
                        if (r_moves == MCW'(CELLS)) begin
                            w_gstate_nxt = 2'b11;
                            w_state_nxt  = S_OVER;
                        end else begin
                            w_turn_nxt  = ~r_turn;
                            w_state_nxt = S_PLAY;
                        end
                    end
                end else begin
                    w_off_nxt = r_off + OW'(1);
                    w_run_nxt = w_run_inc;
                end
            end
`ifdef WIN_HIGHLIGHT_EN
            // Walk back from the offset that completed the run, marking one cell per cycle.
            S_HILITE: begin
                w_hl_nxt[w_tidx] = 1'b1;
                w_off_nxt = r_off - OW'(1);
                w_run_nxt = r_run - RW'(1);
                if (r_run == RW'(1)) w_state_nxt = S_OVER;
            end
`endif
            default: ;
        endcase
        if (w_newgame) begin
            w_board_nxt  = '0;
            w_hl_nxt     = '0;
            w_crow_nxt   = '0;
            w_ccol_nxt   = '0;
            w_turn_nxt   = 1'b0;
            w_gstate_nxt = 2'b00;
            w_moves_nxt  = '0;
            w_state_nxt  = S_PLAY;
        end
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == S_CHECK);
`ifdef WIN_HIGHLIGHT_EN
        w_busy_nxt = w_busy_nxt || (w_state_nxt == S_HILITE);
`endif
        w_ctrl_nxt = '0;
        for (int i = 0; i < CELLS; i++) begin
            w_ctrl_nxt[4*i +: 2] = w_board_nxt[i];
            w_ctrl_nxt[4*i + 2]  = (IW'(i) == w_cidx_nxt);
            w_ctrl_nxt[4*i + 3]  = w_hl_nxt[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_PLAY;
            r_board  <= '0;
            r_hl     <= '0;
            r_crow   <= '0;
            r_ccol   <= '0;
            r_prow   <= '0;
            r_pcol   <= '0;
            r_pmark  <= 2'b00;
            r_dir    <= 2'd0;
            r_off    <= '0;
            r_run    <= '0;
            r_turn   <= 1'b0;
            r_gstate <= 2'b00;
            r_moves  <= '0;
            r_ctrl   <= (4 * CELLS)'(4);
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_board  <= w_board_nxt;
            r_hl     <= w_hl_nxt;
            r_crow   <= w_crow_nxt;
            r_ccol   <= w_ccol_nxt;
            r_prow   <= w_prow_nxt;
            r_pcol   <= w_pcol_nxt;
            r_pmark  <= w_pmark_nxt;
            r_dir    <= w_dir_nxt;
            r_off    <= w_off_nxt;
            r_run    <= w_run_nxt;
            r_turn   <= w_turn_nxt;
            r_gstate <= w_gstate_nxt;
            r_moves  <= w_moves_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_control_array = r_ctrl;
    assign o_turn          = r_turn;
    assign o_game_state    = r_gstate;
    assign o_busy          = r_busy;
endmodule
